fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the core.
//  Issues one instruction-memory request at a time with a valid/ready
//  handshake, and hands fetched words plus their PC to decode.
//  Accepts the execute-stage redirect (branch/jal/jalr target + enable).
//  On a redirect it reloads the PC, discards stale fetches and pulses a
//  flush to younger stages.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded at reset; bits [1:0] must be 0
// PORTS
//  clk             in   1   core clock
//  reset_n         in   1   synchronous, active-low reset
//  run             in   1   level: enable fetching
//  redirect_en     in   1   execute-stage redirect valid (single-cycle)
//  redirect_addr   in   32  redirect target; [1:0] forced to 0 internally
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request this cycle
//  imem_req_addr   out  32  fetch address (= pc)
//  imem_rsp_valid  in   1   fetch response valid (exactly 1 per accepted req)
//  imem_rsp_data   in   32  fetched instruction word
//  inst_valid      out  1   instruction valid to decode
//  inst_ready      in   1   decode accepts instruction
//  inst_data       out  32  instruction word
//  inst_pc         out  32  PC of inst_data
//  flush           out  1   1-cycle pulse: kill younger in-flight instrs
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, pc=RESET_PC, drop_pending=0.
//   imem_req_valid=0, inst_valid=0, flush=0, inst_data/inst_pc=0.
//  States: IDLE, REQ, WAIT, HOLD; all outputs are registered or decoded
//   from the state register only, with no combinational in->out path.
//  IDLE: outputs idle; run=1 -> REQ.
//  REQ:  imem_req_valid=1, imem_req_addr=pc; imem_req_ready=1 -> WAIT.
//  WAIT: imem_rsp_valid=1 -> latch data, inst_pc<=pc, pc<=pc+4 (mod 2^32,
//        wraps silently at 32'hFFFF_FFFC), -> HOLD.
//  HOLD: inst_valid=1; inst_ready=1 -> (run ? REQ : IDLE).
//  Request/transfer: a request is accepted when valid&ready at a posedge.
//   Address and valid are held stable until that edge.
//  Throughput: 1 instr / 3 cycles with ready tied high (REQ,WAIT,HOLD);
//   this is intentional, no pipelining of requests.
//  run=0 outside IDLE: the current request completes, and the block
//   returns to IDLE after the HOLD handoff. IDLE/REQ with run=0 and no
//   acceptance -> IDLE.
//  Redirect (redirect_en=1 at posedge, any state, takes priority):
//   - pc <= {redirect_addr[31:2],2'b00}; flush=1 next cycle, for 1 cycle.
//   - From IDLE: state stays IDLE, and pc is updated.
//   - Otherwise: next state=REQ.
//   - REQ with imem_req_ready=1 at the same edge: the request counts as
//     accepted, so drop_pending<=1.
//   - WAIT with imem_rsp_valid=0: drop_pending<=1. With imem_rsp_valid=1
//     at the same edge: the response is discarded and drop_pending stays 0.
//   - HOLD: buffered instruction dropped, inst_valid=0 next cycle, even if
//     inst_ready=1 at the same edge. Decode ignores that transfer due to
//     flush.
//  drop_pending=1: in REQ, imem_req_valid is held 0 until the stale
//   response arrives. That response is discarded and clears drop_pending.
//   At most one outstanding request ever exists.
//  Back-to-back redirects: the last one wins, and flush stays high for
//   each cycle following a redirect.
//  Reset mid-operation: returns to reset state next edge and clears
//   drop_pending. The bench/imem must not return a response after reset.
// STRUCTURE
//  Package core_pkg: typedef enum logic [1:0] fetch_state_t {IDLE,REQ,
//   WAIT,HOLD}; localparam INST_BYTES=4; addr_t = logic [31:0].
//  Single module; no sub-module (state machine + pc/buffer registers).
// TESTING
//  1 Reset, run=1, imem ready=1, 1-cycle rsp: inst_pc 0,4,8 delivered
//    every 3 cycles, with flush never asserted.
//  2 inst_ready=0 for 5 cycles in HOLD: inst_valid, inst_data and inst_pc
//    held stable, and no new imem request is issued.
//  3 Redirect to 32'h0000_0103 during WAIT: flush pulses 1 cycle. The
//    stale rsp is dropped, and the next req addr is 32'h0000_0100.
//  4 Redirect on the same edge as imem_rsp_valid: word discarded, with no
//    drop_pending. The next req goes to the target on the following cycle.
//  5 RESET_PC=32'hFFFF_FFFC: second fetch address is 32'h0000_0000 (wrap).
//  6 Assert reset_n=0 while in WAIT: next cycle all outputs are at reset
//    values, and pc equals RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the fetch front end
package core_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  localparam int INST_BYTES = 4;

  typedef logic [31:0] addr_t;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter owner and single-outstanding instruction fetch sequencer
module fetch_sequencer
  import core_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        flush
);

  fetch_state_t state;
  addr_t        pc;
  logic         drop_pending;
  logic         req_fire;
  logic         stale_rsp;
  addr_t        redirect_target;
  logic         unused_addr_bits;

  // Handshake outputs are decoded purely from registered state, so there is
  // no combinational path from any input to any output.
  assign imem_req_valid   = (state == REQ) && !drop_pending;
  assign imem_req_addr    = pc;
  assign inst_valid       = (state == HOLD);

  assign req_fire         = imem_req_valid && imem_req_ready;
  // A response while a drop is owed always belongs to the abandoned request.
  assign stale_rsp        = drop_pending && imem_rsp_valid;
  assign redirect_target  = {redirect_addr[31:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr[1:0];

  // Fetch FSM with pc, instruction buffer, stale-response tracking and flush pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      drop_pending <= 1'b0;
      flush        <= 1'b0;
      inst_data    <= '0;
      inst_pc      <= '0;
    end else begin
      flush <= redirect_en;
      if (redirect_en) begin
        pc <= redirect_target;
        if (state != IDLE) begin
          state <= REQ;
        end
        case (state)
          // A request accepted on the redirect edge still gets a response
          // that must be swallowed later.
          REQ: begin
            if (req_fire) begin
              drop_pending <= 1'b1;
            end else if (stale_rsp) begin
              drop_pending <= 1'b0;
            end
          end
          // A response landing on the redirect edge is simply ignored here.
          WAIT: drop_pending <= !imem_rsp_valid;
          default: begin
            if (stale_rsp) begin
              drop_pending <= 1'b0;
            end
          end
        endcase
      end else begin
        if (stale_rsp) begin
          drop_pending <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (run) begin
              state <= REQ;
            end
          end
          REQ: begin
            if (req_fire) begin
              state <= WAIT;
            end else if (!run) begin
              state <= IDLE;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              inst_data <= imem_rsp_data;
              inst_pc   <= pc;
              pc        <= pc + addr_t'(INST_BYTES);
              state     <= HOLD;
            end
          end
          HOLD: begin
            if (inst_ready) begin
              state <= run ? REQ : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        flush;

  logic        run2 = 1'b0;
  logic        imem_rsp_valid2 = 1'b0;
  logic [31:0] imem_rsp_data2 = '0;
  logic        imem_req_valid2;
  logic [31:0] imem_req_addr2;
  logic        inst_valid2;
  logic [31:0] inst_data2;
  logic [31:0] inst_pc2;
  logic        flush2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int flush_cnt = 0;

  bit          pending = 1'b0;
  logic [31:0] pend_addr = '0;
  bit          rsp_hold = 1'b0;

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .flush(flush)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .run(run2),
    .redirect_en(1'b0), .redirect_addr(32'h0),
    .imem_req_valid(imem_req_valid2), .imem_req_ready(1'b1),
    .imem_req_addr(imem_req_addr2), .imem_rsp_valid(imem_rsp_valid2),
    .imem_rsp_data(imem_rsp_data2), .inst_valid(inst_valid2),
    .inst_ready(1'b1), .inst_data(inst_data2), .inst_pc(inst_pc2),
    .flush(flush2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // imem model: one response, one cycle after acceptance, unless held
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (pending && !rsp_hold) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend_addr);
      pending        = 1'b0;
    end
    if (imem_req_valid && imem_req_ready) begin
      pending   = 1'b1;
      pend_addr = imem_req_addr;
    end
    if (flush) flush_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_inst(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (inst_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    vectors++;
    if ({imem_req_valid, inst_valid, flush} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000", {imem_req_valid, inst_valid, flush});
    end
    vectors++;
    if (inst_data !== 32'h0 || inst_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: data %h pc %h addr %h want 0", inst_data, inst_pc, imem_req_addr);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    bit ok;
    int last;
    int fc;
    fc = flush_cnt;
    last = 0;
    inst_ready = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_inst(ok);
      vectors++;
      if (!ok || inst_pc !== 32'(4 * i) || inst_data !== word_of(32'(4 * i))) begin
        miscompares++;
        $display("FAIL stream_inst%0d: ok %0d pc %h data %h want pc %h", i, ok, inst_pc, inst_data, 4 * i);
      end
      if (i > 0) begin
        vectors++;
        if (cyc - last !== 3) begin
          miscompares++;
          $display("FAIL stream_rate%0d: got %0d cycles want 3", i, cyc - last);
        end
      end
      last = cyc;
    end
    run = 1'b0;
    step();
    step();
    vectors++;
    if (flush_cnt !== fc) begin
      miscompares++;
      $display("FAIL stream_flush: got %0d pulses want 0", flush_cnt - fc);
    end
  endtask

  task automatic test_hold_stall();
    bit ok;
    inst_ready = 1'b0;
    run = 1'b1;
    wait_inst(ok);
    vectors++;
    if (!ok || inst_pc !== 32'hC) begin
      miscompares++;
      $display("FAIL stall_arrive: ok %0d pc %h want 0000000c", ok, inst_pc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hC || inst_data !== word_of(32'hC) || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: v %b pc %h data %h req %b", i, inst_valid, inst_pc, inst_data, imem_req_valid);
      end
    end
    inst_ready = 1'b1;
    run = 1'b0;
    step();
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: inst_valid %b want 0", inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int fc;
    rsp_hold = 1'b1;
    run = 1'b1;
    step();
    step();
    redirect_en = 1'b1;
    redirect_addr = 32'h0000_0103;
    fc = flush_cnt;
    step();
    redirect_en = 1'b0;
    vectors++;
    if (flush !== 1'b1 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_wait_flush: flush %b req %b want 1 0", flush, imem_req_valid);
    end
    rsp_hold = 1'b0;
    step();
    vectors++;
    if (flush !== 1'b0 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_wait_drop: flush %b req %b want 0 0", flush, imem_req_valid);
    end
    step();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100 || flush_cnt - fc !== 1) begin
      miscompares++;
      $display("FAIL redir_wait_req: req %b addr %h pulses %0d want 1 00000100 1", imem_req_valid, imem_req_addr, flush_cnt - fc);
    end
    wait_inst(ok);
    vectors++;
    if (!ok || inst_pc !== 32'h100 || inst_data !== word_of(32'h100)) begin
      miscompares++;
      $display("FAIL redir_wait_inst: ok %0d pc %h data %h want pc 00000100", ok, inst_pc, inst_data);
    end
    run = 1'b0;
    step();
    step();
  endtask

  task automatic test_redirect_same_edge();
    bit ok;
    run = 1'b1;
    step();
    step();
    redirect_en = 1'b1;
    redirect_addr = 32'h0000_0200;
    step();
    redirect_en = 1'b0;
    vectors++;
    if (flush !== 1'b1 || inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL redir_edge_req: flush %b inst_v %b req %b addr %h want 1 0 1 00000200", flush, inst_valid, imem_req_valid, imem_req_addr);
    end
    wait_inst(ok);
    vectors++;
    if (!ok || inst_pc !== 32'h200 || inst_data !== word_of(32'h200)) begin
      miscompares++;
      $display("FAIL redir_edge_inst: ok %0d pc %h data %h want pc 00000200", ok, inst_pc, inst_data);
    end
    run = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    rsp_hold = 1'b1;
    run = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    step();
    vectors++;
    if ({imem_req_valid, inst_valid, flush} !== 3'b000 || inst_data !== 32'h0 || inst_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: ctrl %b data %h pc %h addr %h want 000 0 0 0", {imem_req_valid, inst_valid, flush}, inst_data, inst_pc, imem_req_addr);
    end
    pending = 1'b0;
    rsp_hold = 1'b0;
    reset_n = 1'b1;
    step();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_restart: req %b addr %h want 1 00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    redirect_en = 1'b1;
    redirect_addr = 32'h0000_0300;
    step();
    vectors++;
    if (flush !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_flush1: got %b want 1", flush);
    end
    redirect_addr = 32'h0000_0404;
    step();
    redirect_en = 1'b0;
    vectors++;
    if (flush !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h404) begin
      miscompares++;
      $display("FAIL b2b_flush2: flush %b req %b addr %h want 1 1 00000404", flush, imem_req_valid, imem_req_addr);
    end
    step();
    vectors++;
    if (flush !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_flush_end: got %b want 0", flush);
    end
    wait_inst(ok);
    vectors++;
    if (!ok || inst_pc !== 32'h404 || inst_data !== word_of(32'h404)) begin
      miscompares++;
      $display("FAIL b2b_inst: ok %0d pc %h data %h want pc 00000404", ok, inst_pc, inst_data);
    end
    run = 1'b0;
    step();
    step();
  endtask

  task automatic test_wrap();
    run2 = 1'b1;
    step();
    vectors++;
    if (imem_req_valid2 !== 1'b1 || imem_req_addr2 !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_req0: req %b addr %h want 1 fffffffc", imem_req_valid2, imem_req_addr2);
    end
    step();
    imem_rsp_valid2 = 1'b1;
    imem_rsp_data2 = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid2 = 1'b0;
    vectors++;
    if (inst_valid2 !== 1'b1 || inst_pc2 !== 32'hFFFF_FFFC || inst_data2 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wrap_inst: v %b pc %h data %h want 1 fffffffc deadbeef", inst_valid2, inst_pc2, inst_data2);
    end
    step();
    vectors++;
    if (imem_req_valid2 !== 1'b1 || imem_req_addr2 !== 32'h0000_0000 || flush2 !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_req1: req %b addr %h flush %b want 1 00000000 0", imem_req_valid2, imem_req_addr2, flush2);
    end
    run2 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_same_edge();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
